// File: rtl/aclock_pkg.sv
// Shared types and constants for the alarm clock ringing stage.
package aclock_pkg;

  // Ringing-stage states; encoding is fixed so debug dumps read the same everywhere.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRing   = 2'd1,
    StSnooze = 2'd2
  } state_e;

  // Default timing constants, in seconds of clk_1s.
  localparam int unsigned RING_SECS_DEF   = 60;
  localparam int unsigned SNOOZE_SECS_DEF = 300;
  localparam int unsigned MAX_SNOOZE_DEF  = 3;

  // BCD digit widths: hour tens needs only 2 bits, the rest 4.
  localparam int unsigned H1_W  = 2;
  localparam int unsigned DIG_W = 4;

  // 4-bit increment that sticks at 15.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/aclock_btn_edge.sv
// Two-channel rising-edge detector: edge_o[i] is high for the one cycle in which
// btn_i[i] is high and was low at the previous clk_1s edge.
module aclock_btn_edge (
  input  logic       clk_1s,
  input  logic       reset,
  input  logic [1:0] btn_i,
  output logic [1:0] edge_o
);

  logic [1:0] prev_d, prev_q;

  // History always tracks the live button level so a held button fires once.
  always_comb begin
    prev_d = btn_i;
    edge_o = btn_i & ~prev_q;
  end

  // Button history register.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      prev_q <= 2'b00;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/aclock_snooze_ctrl.sv
// Ringing-phase controller downstream of the alarm clock core: acknowledges the
// core alarm, beeps at 1 Hz, handles snooze/stop, times out unattended rings and
// records the time at which the most recent alarm event started.
module aclock_snooze_ctrl
  import aclock_pkg::*;
#(
  parameter int unsigned RING_SECS   = RING_SECS_DEF,
  parameter int unsigned SNOOZE_SECS = SNOOZE_SECS_DEF,
  parameter int unsigned MAX_SNOOZE  = MAX_SNOOZE_DEF,
  parameter int unsigned CNT_W       = 9
) (
  input  logic             clk_1s,
  input  logic             reset,
  input  logic             alarm_in,
  input  logic             snooze_btn,
  input  logic             stop_btn,
  input  logic [H1_W-1:0]  t_h1,
  input  logic [DIG_W-1:0] t_h0,
  input  logic [DIG_W-1:0] t_m1,
  input  logic [DIG_W-1:0] t_m0,
  output logic             stop_al,
  output logic             buzzer,
  output logic             ringing,
  output logic             snoozing,
  output logic [CNT_W-1:0] secs_left,
  output logic [1:0]       snooze_cnt,
  output logic [3:0]       missed_cnt,
  output logic [H1_W-1:0]  ev_h1,
  output logic [DIG_W-1:0] ev_h0,
  output logic [DIG_W-1:0] ev_m1,
  output logic [DIG_W-1:0] ev_m0
);

  localparam logic [CNT_W-1:0] RingLd = CNT_W'(RING_SECS);
  localparam logic [CNT_W-1:0] SnzLd  = CNT_W'(SNOOZE_SECS);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [1:0]       SnzMax = 2'(MAX_SNOOZE);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             buzzer_d, buzzer_q;
  logic [1:0]       snooze_cnt_d, snooze_cnt_q;
  logic [3:0]       missed_d, missed_q;
  logic             stop_al_d, stop_al_q;
  logic [H1_W-1:0]  ev_h1_d, ev_h1_q;
  logic [DIG_W-1:0] ev_h0_d, ev_h0_q;
  logic [DIG_W-1:0] ev_m1_d, ev_m1_q;
  logic [DIG_W-1:0] ev_m0_d, ev_m0_q;

  logic [1:0] btn_edge;
  logic       snz_edge, stp_edge;

  aclock_btn_edge u_btn_edge (
    .clk_1s (clk_1s),
    .reset  (reset),
    .btn_i  ({stop_btn, snooze_btn}),
    .edge_o (btn_edge)
  );

  assign snz_edge = btn_edge[0];
  assign stp_edge = btn_edge[1];

  // Next-state logic for the ring/snooze FSM, its counter and event bookkeeping.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buzzer_d     = buzzer_q;
    snooze_cnt_d = snooze_cnt_q;
    missed_d     = missed_q;
    ev_h1_d      = ev_h1_q;
    ev_h0_d      = ev_h0_q;
    ev_m1_d      = ev_m1_q;
    ev_m0_d      = ev_m0_q;
    // The core clears Alarm on the edge after it sees this acknowledge.
    stop_al_d    = alarm_in;

    case (state_q)
      StIdle: begin
        buzzer_d = 1'b0;
        cnt_d    = '0;
        if (alarm_in) begin
          state_d      = StRing;
          cnt_d        = RingLd;
          snooze_cnt_d = 2'd0;
          buzzer_d     = 1'b1;
          ev_h1_d      = t_h1;
          ev_h0_d      = t_h0;
          ev_m1_d      = t_m1;
          ev_m0_d      = t_m0;
        end
      end

      StRing: begin
        if (stp_edge) begin
          state_d      = StIdle;
          cnt_d        = '0;
          buzzer_d     = 1'b0;
          snooze_cnt_d = 2'd0;
        end else if (snz_edge && (snooze_cnt_q < SnzMax)) begin
          state_d      = StSnooze;
          cnt_d        = SnzLd;
          buzzer_d     = 1'b0;
          snooze_cnt_d = snooze_cnt_q + 2'd1;
        end else if (cnt_q == CntOne) begin
          // Nobody answered: count it as missed.
          state_d      = StIdle;
          cnt_d        = '0;
          buzzer_d     = 1'b0;
          snooze_cnt_d = 2'd0;
          missed_d     = sat_inc4(missed_q);
        end else begin
          cnt_d    = cnt_q - CntOne;
          buzzer_d = ~buzzer_q;
        end
      end

      StSnooze: begin
        buzzer_d = 1'b0;
        if (stp_edge) begin
          state_d      = StIdle;
          cnt_d        = '0;
          snooze_cnt_d = 2'd0;
        end else if (cnt_q == CntOne) begin
          // Re-ring keeps the original event time and snooze count.
          state_d  = StRing;
          cnt_d    = RingLd;
          buzzer_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      default: begin
        state_d      = StIdle;
        cnt_d        = '0;
        buzzer_d     = 1'b0;
        snooze_cnt_d = 2'd0;
      end
    endcase
  end

  // State registers; reset returns everything, including missed_cnt, to zero.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      buzzer_q     <= 1'b0;
      snooze_cnt_q <= 2'd0;
      missed_q     <= 4'd0;
      stop_al_q    <= 1'b0;
      ev_h1_q      <= '0;
      ev_h0_q      <= '0;
      ev_m1_q      <= '0;
      ev_m0_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buzzer_q     <= buzzer_d;
      snooze_cnt_q <= snooze_cnt_d;
      missed_q     <= missed_d;
      stop_al_q    <= stop_al_d;
      ev_h1_q      <= ev_h1_d;
      ev_h0_q      <= ev_h0_d;
      ev_m1_q      <= ev_m1_d;
      ev_m0_q      <= ev_m0_d;
    end
  end

  // Output decode.
  always_comb begin
    ringing    = (state_q == StRing);
    snoozing   = (state_q == StSnooze);
    secs_left  = (state_q == StIdle) ? '0 : cnt_q;
    stop_al    = stop_al_q;
    buzzer     = buzzer_q;
    snooze_cnt = snooze_cnt_q;
    missed_cnt = missed_q;
    ev_h1      = ev_h1_q;
    ev_h0      = ev_h0_q;
    ev_m1      = ev_m1_q;
    ev_m0      = ev_m0_q;
  end

endmodule

// File: tb/tb_aclock_snooze_ctrl.sv
// Bench for aclock_snooze_ctrl with default parameters (60 s ring, 300 s snooze,
// 3 snoozes). Expected outputs are queued as each stimulus is driven and
// compared one time unit after the following clk_1s edge.
module tb_aclock_snooze_ctrl;

  logic       clk_1s = 1'b0;
  logic       reset;
  logic       alarm_in, snooze_btn, stop_btn;
  logic [1:0] t_h1;
  logic [3:0] t_h0, t_m1, t_m0;
  logic       stop_al, buzzer, ringing, snoozing;
  logic [8:0] secs_left;
  logic [1:0] snooze_cnt;
  logic [3:0] missed_cnt;
  logic [1:0] ev_h1;
  logic [3:0] ev_h0, ev_m1, ev_m0;

  int total = 0;
  int bad   = 0;

  aclock_snooze_ctrl dut (
    .clk_1s     (clk_1s),
    .reset      (reset),
    .alarm_in   (alarm_in),
    .snooze_btn (snooze_btn),
    .stop_btn   (stop_btn),
    .t_h1       (t_h1),
    .t_h0       (t_h0),
    .t_m1       (t_m1),
    .t_m0       (t_m0),
    .stop_al    (stop_al),
    .buzzer     (buzzer),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .secs_left  (secs_left),
    .snooze_cnt (snooze_cnt),
    .missed_cnt (missed_cnt),
    .ev_h1      (ev_h1),
    .ev_h0      (ev_h0),
    .ev_m1      (ev_m1),
    .ev_m0      (ev_m0)
  );

  always #5 clk_1s = ~clk_1s;

  typedef struct packed {
    logic       ringing;
    logic       snoozing;
    logic       buzzer;
    logic       stop_al;
    logic [8:0] secs;
    logic [1:0] scnt;
    logic [3:0] missed;
  } out_t;

  typedef struct {
    logic alarm;
    logic snz;
    logic stp;
    out_t exp;
  } vec_t;

  out_t  exp_q[$];
  string name_q[$];

  function automatic out_t mk(input logic r, input logic s, input logic b, input logic sa,
                              input int secs, input int scnt, input int missed);
    out_t o;
    o.ringing  = r;
    o.snoozing = s;
    o.buzzer   = b;
    o.stop_al  = sa;
    o.secs     = 9'(secs);
    o.scnt     = 2'(scnt);
    o.missed   = 4'(missed);
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("ring=%0b snz=%0b buz=%0b stop_al=%0b secs=%0d snz_cnt=%0d missed=%0d",
                     o.ringing, o.snoozing, o.buzzer, o.stop_al, o.secs, o.scnt, o.missed);
  endfunction

  task automatic push_exp(input string nm, input out_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic pop_check();
    out_t  e, a;
    string nm;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: got empty queue, required a pending expectation");
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    a  = {ringing, snoozing, buzzer, stop_al, secs_left, snooze_cnt, missed_cnt};
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %s, required %s", nm, fmt(a), fmt(e));
    end
  endtask

  task automatic check_ev(input string nm, input logic [1:0] h1, input logic [3:0] h0,
                          input logic [3:0] m1, input logic [3:0] m0);
    total++;
    if ({ev_h1, ev_h0, ev_m1, ev_m0} !== {h1, h0, m1, m0}) begin
      bad++;
      $display("FAIL %s: got ev=%0d%0d:%0d%0d, required %0d%0d:%0d%0d", nm,
               ev_h1, ev_h0, ev_m1, ev_m0, h1, h0, m1, m0);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input logic al, input logic snz, input logic stp, input string nm,
                      input out_t e);
    alarm_in   = al;
    snooze_btn = snz;
    stop_btn   = stp;
    push_exp(nm, e);
    @(posedge clk_1s);
    #1;
    pop_check();
  endtask

  // One ring left unattended from IDLE until its timeout.
  task automatic ring_unattended(input int mb, input int ma);
    step(1'b1, 1'b0, 1'b0, "ring_start", mk(1, 0, 1, 1, 60, 0, mb));
    for (int i = 1; i < 60; i++) begin
      step(1'b0, 1'b0, 1'b0, "ring_run", mk(1, 0, (i % 2) == 0, 0, 60 - i, 0, mb));
    end
    step(1'b0, 1'b0, 1'b0, "ring_timeout", mk(0, 0, 0, 0, 0, 0, ma));
  endtask

  // From RING with snooze released: press snooze (held for 'hold' cycles), run the
  // full snooze and land back in RING.
  task automatic run_snooze(input int hold, input int scnt, input int missed);
    logic s;
    step(1'b0, 1'b1, 1'b0, "snz_enter", mk(0, 1, 0, 0, 300, scnt, missed));
    for (int k = 2; k <= 300; k++) begin
      s = (k <= hold);
      step(1'b0, s, 1'b0, "snz_run", mk(0, 1, 0, 0, 301 - k, scnt, missed));
    end
    step(1'b0, 1'b0, 1'b0, "snz_rering", mk(1, 0, 1, 0, 60, scnt, missed));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    out_t idle0;

    idle0 = mk(0, 0, 0, 0, 0, 0, 0);
    vecs[0] = '{1'b1, 1'b0, 1'b0, mk(1, 0, 1, 1, 60, 0, 0)};
    vecs[1] = '{1'b1, 1'b0, 1'b0, mk(1, 0, 0, 1, 59, 0, 0)};
    vecs[2] = '{1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 58, 0, 0)};
    vecs[3] = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 57, 0, 0)};
    vecs[4] = '{1'b0, 1'b0, 1'b1, idle0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, idle0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, idle0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, idle0};

    reset      = 1'b1;
    alarm_in   = 1'b0;
    snooze_btn = 1'b0;
    stop_btn   = 1'b0;
    t_h1 = 2'd0; t_h0 = 4'd7; t_m1 = 4'd3; t_m0 = 4'd0;

    #3;
    push_exp("reset_state", idle0);
    pop_check();
    check_ev("reset_ev", 2'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk_1s);
    reset = 1'b0;

    // Alarm at 07:30, buzzer pattern, stop, buttons ignored in IDLE.
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].alarm, vecs[i].snz, vecs[i].stp, $sformatf("vec%0d", i), vecs[i].exp);
      if (i == 0) begin
        check_ev("ev_latch", 2'd0, 4'd7, 4'd3, 4'd0);
        t_h1 = 2'd1; t_h0 = 4'd2; t_m1 = 4'd4; t_m0 = 4'd5;
      end
    end
    check_ev("ev_hold", 2'd0, 4'd7, 4'd3, 4'd0);

    // Unattended ring times out after exactly 60 cycles.
    ring_unattended(0, 1);
    check_ev("ev_relatch", 2'd1, 4'd2, 4'd4, 4'd5);

    // Held snooze acts once; full snooze then re-ring.
    step(1'b1, 1'b0, 1'b0, "t3_ring", mk(1, 0, 1, 1, 60, 0, 1));
    run_snooze(5, 1, 1);

    // Snooze limit: fourth press ignored, stop clears the count.
    run_snooze(1, 2, 1);
    run_snooze(1, 3, 1);
    step(1'b0, 1'b1, 1'b0, "snz_limit", mk(1, 0, 0, 0, 59, 3, 1));
    step(1'b0, 1'b0, 1'b0, "snz_limit_run", mk(1, 0, 1, 0, 58, 3, 1));
    step(1'b0, 1'b0, 1'b1, "t4_stop", mk(0, 0, 0, 0, 0, 0, 1));
    step(1'b0, 1'b0, 1'b0, "t4_idle", mk(0, 0, 0, 0, 0, 0, 1));
    check_ev("ev_after_snz", 2'd1, 4'd2, 4'd4, 4'd5);

    // Stop and snooze on the same edge: stop wins.
    step(1'b1, 1'b0, 1'b0, "t5_ring", mk(1, 0, 1, 1, 60, 0, 1));
    run_snooze(1, 1, 1);
    step(1'b0, 1'b1, 1'b1, "both_btn", mk(0, 0, 0, 0, 0, 0, 1));
    step(1'b0, 1'b0, 1'b0, "t5_idle", mk(0, 0, 0, 0, 0, 0, 1));

    // Asynchronous reset mid-snooze, then a fresh event.
    step(1'b1, 1'b0, 1'b0, "t6_ring", mk(1, 0, 1, 1, 60, 0, 1));
    step(1'b0, 1'b1, 1'b0, "t6_snz", mk(0, 1, 0, 0, 300, 1, 1));
    for (int k = 1; k <= 150; k++) begin
      step(1'b0, 1'b0, 1'b0, "t6_run", mk(0, 1, 0, 0, 300 - k, 1, 1));
    end
    #2;
    reset = 1'b1;
    #1;
    push_exp("reset_async", idle0);
    pop_check();
    check_ev("reset_async_ev", 2'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk_1s);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, "t6_fresh", mk(1, 0, 1, 1, 60, 0, 0));
    check_ev("ev_fresh", 2'd1, 4'd2, 4'd4, 4'd5);
    step(1'b0, 1'b1, 1'b0, "t6_snz_again", mk(0, 1, 0, 0, 300, 1, 0));
    step(1'b0, 1'b0, 1'b0, "t6_snz_dec", mk(0, 1, 0, 0, 299, 1, 0));
    step(1'b0, 1'b0, 1'b1, "snz_stop", mk(0, 0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b0, 1'b0, "t6_idle", mk(0, 0, 0, 0, 0, 0, 0));

    // missed_cnt saturates at 15.
    for (int n = 0; n < 16; n++) begin
      ring_unattended((n < 15) ? n : 15, (n + 1 < 15) ? n + 1 : 15);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
